// File: rtl/topview_pkg.sv
// rtl/topview_pkg.sv - shared widths, raster FSM states and segment word layout for the topview line rasterizer
// Contents: default map geometry, derived coordinate widths, segment-table address width,
//           raster_state_t, segment_t (BRAM word order) and the Bresenham arithmetic width helper.
package topview_pkg;

   localparam int TV_OUT_WIDTH  = 640;
   localparam int TV_OUT_HEIGHT = 480;
   localparam int TV_OUT_H_BITW = $clog2(TV_OUT_WIDTH);
   localparam int TV_OUT_V_BITW = $clog2(TV_OUT_HEIGHT);
   localparam int TV_RAM_ADDR_W = 12;

   typedef enum logic [2:0] {
      RS_IDLE = 3'd0,
      RS_ADDR = 3'd1,
      RS_LOAD = 3'd2,
      RS_DRAW = 3'd3,
      RS_FIN  = 3'd4
   } raster_state_t;

   typedef struct packed {
      logic [TV_OUT_V_BITW-1:0] v0;
      logic [TV_OUT_H_BITW-1:0] h0;
      logic [TV_OUT_V_BITW-1:0] v1;
      logic [TV_OUT_H_BITW-1:0] h1;
      logic                     valid;
   } segment_t;

   // Signed width holding dx, dy, err and 2*err: one bit for sign, one for the doubling.
   function automatic int raster_w(input int hb, input int vb);
      return ((hb > vb) ? hb : vb) + 2;
   endfunction

endpackage

// File: rtl/bresenham_stepper.sv
// rtl/bresenham_stepper.sv - integer Bresenham walker producing one (v,h) point per step
// Ports: clk, n_rst (async active-low); load latches endpoints and initial error terms;
//        step advances one point (ignored once last); v/h current point; last = current equals end point.
module bresenham_stepper
   import topview_pkg::*;
#(
   parameter int HW = TV_OUT_H_BITW,
   parameter int VW = TV_OUT_V_BITW,
   parameter int W  = raster_w(HW, VW)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          load,
   input  logic          step,
   input  logic [VW-1:0] v0,
   input  logic [HW-1:0] h0,
   input  logic [VW-1:0] v1,
   input  logic [HW-1:0] h1,
   output logic [VW-1:0] v,
   output logic [HW-1:0] h,
   output logic          last
);

   logic [VW-1:0]       v_end;
   logic [HW-1:0]       h_end;
   logic signed [W-1:0] dx, dy, err;
   logic                sh_neg, sv_neg;
   logic signed [W-1:0] dh, dv, dx_ld, dy_ld, e2, err_nx;
   logic                h_mv, v_mv;

   // Endpoints are unsigned, so zero-extend before the signed subtraction.
   assign dh    = $signed(W'(h1)) - $signed(W'(h0));
   assign dv    = $signed(W'(v1)) - $signed(W'(v0));
   assign dx_ld = dh[W-1] ? -dh : dh;
   assign dy_ld = dv[W-1] ? dv : -dv;

   assign e2     = err <<< 1;
   assign h_mv   = (e2 >= dy);
   assign v_mv   = (e2 <= dx);
   assign err_nx = err + (h_mv ? dy : W'(0)) + (v_mv ? dx : W'(0));
   assign last   = (v == v_end) && (h == h_end);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         v      <= '0;
         h      <= '0;
         v_end  <= '0;
         h_end  <= '0;
         dx     <= '0;
         dy     <= '0;
         err    <= '0;
         sh_neg <= 1'b0;
         sv_neg <= 1'b0;
      end else if (load) begin
         v      <= v0;
         h      <= h0;
         v_end  <= v1;
         h_end  <= h1;
         dx     <= dx_ld;
         dy     <= dy_ld;
         err    <= dx_ld + dy_ld;
         sh_neg <= dh[W-1];
         sv_neg <= dv[W-1];
      end else if (step && !last) begin
         err <= err_nx;
         if (h_mv) h <= sh_neg ? h - HW'(1) : h + HW'(1);
         if (v_mv) v <= sv_neg ? v - VW'(1) : v + VW'(1);
      end
   end

endmodule

// File: rtl/topview_line_raster.sv
// rtl/topview_line_raster.sv - walks the topview segment table and streams rasterized pixel coordinates
// Ports: clk, n_rst (async active-low); ready/line_num from the topview stage; raddr and rd_* form the
//        one-cycle-latency table read; pix_valid/pix_ready/pix_v/pix_h pixel stream; busy, done, seg_drawn status.
module topview_line_raster
   import topview_pkg::*;
#(
   parameter  int OUT_WIDTH  = TV_OUT_WIDTH,
   parameter  int OUT_HEIGHT = TV_OUT_HEIGHT,
   parameter  int RAM_ADDR_W = TV_RAM_ADDR_W,
   localparam int OUT_H_BITW = $clog2(OUT_WIDTH),
   localparam int OUT_V_BITW = $clog2(OUT_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  ready,
   input  logic [RAM_ADDR_W-1:0] line_num,
   output logic [RAM_ADDR_W-1:0] raddr,
   input  logic [OUT_V_BITW-1:0] rd_start_v,
   input  logic [OUT_V_BITW-1:0] rd_end_v,
   input  logic [OUT_H_BITW-1:0] rd_start_h,
   input  logic [OUT_H_BITW-1:0] rd_end_h,
   input  logic                  rd_valid,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic [OUT_V_BITW-1:0] pix_v,
   output logic [OUT_H_BITW-1:0] pix_h,
   output logic                  busy,
   output logic                  done,
   output logic [RAM_ADDR_W-1:0] seg_drawn
);

   localparam logic [2:0] S_IDLE = RS_IDLE;
   localparam logic [2:0] S_ADDR = RS_ADDR;
   localparam logic [2:0] S_LOAD = RS_LOAD;
   localparam logic [2:0] S_DRAW = RS_DRAW;
   localparam logic [2:0] S_FIN  = RS_FIN;

   logic [2:0]            state;
   logic [RAM_ADDR_W-1:0] idx, idx_inc;
   logic                  served, accept, last, walk_end, seg_load, seg_step;

   assign idx_inc   = idx + RAM_ADDR_W'(1);
   assign walk_end  = (idx_inc == line_num);
   assign pix_valid = (state == S_DRAW);
   assign done      = (state == S_FIN);
   assign accept    = pix_valid && pix_ready;
   // rd_* carry the word addressed during ADDR, so LOAD is the capture cycle.
   assign seg_load  = (state == S_LOAD) && rd_valid;
   assign seg_step  = accept && ready;

   bresenham_stepper #(
      .HW (OUT_H_BITW),
      .VW (OUT_V_BITW)
   ) u_stepper (
      .clk   (clk),
      .n_rst (n_rst),
      .load  (seg_load),
      .step  (seg_step),
      .v0    (rd_start_v),
      .h0    (rd_start_h),
      .v1    (rd_end_v),
      .h1    (rd_end_h),
      .v     (pix_v),
      .h     (pix_h),
      .last  (last)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         raddr     <= '0;
         busy      <= 1'b0;
         served    <= 1'b0;
         seg_drawn <= '0;
      end else begin
         // served blocks a second walk of the same frame until ready is withdrawn.
         if (!ready) served <= 1'b0;

         if (!ready && state != S_IDLE) begin
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (ready && !served) begin
                     idx       <= '0;
                     raddr     <= '0;
                     seg_drawn <= '0;
                     busy      <= 1'b1;
                     state     <= (line_num == '0) ? S_FIN : S_ADDR;
                  end
               end
               S_ADDR: state <= S_LOAD;
               S_LOAD: begin
                  if (rd_valid) begin
                     state <= S_DRAW;
                  end else begin
                     idx <= idx_inc;
                     if (walk_end) begin
                        state <= S_FIN;
                     end else begin
                        raddr <= idx_inc;
                        state <= S_ADDR;
                     end
                  end
               end
               S_DRAW: begin
                  if (accept && last) begin
                     seg_drawn <= seg_drawn + RAM_ADDR_W'(1);
                     idx       <= idx_inc;
                     if (walk_end) begin
                        state <= S_FIN;
                     end else begin
                        raddr <= idx_inc;
                        state <= S_ADDR;
                     end
                  end
               end
               S_FIN: begin
                  served <= 1'b1;
                  busy   <= 1'b0;
                  state  <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_topview_line_raster.sv
// tb/tb_topview_line_raster.sv - self-checking bench for topview_line_raster
module tb_topview_line_raster;
   import topview_pkg::*;

   localparam int HW = TV_OUT_H_BITW;
   localparam int VW = TV_OUT_V_BITW;
   localparam int AW = TV_RAM_ADDR_W;

   logic          clk = 1'b0;
   logic          n_rst, ready, pix_ready, rd_valid, pix_valid, busy, done;
   logic [AW-1:0] line_num, raddr, seg_drawn;
   logic [VW-1:0] rd_start_v, rd_end_v, pix_v;
   logic [HW-1:0] rd_start_h, rd_end_h, pix_h;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   segment_t tbl [16];

   int got_q[$];
   int exp_q[$];
   int raddr_q[$];
   int done_cnt, done_cyc, last_acc_cyc, first_valid_cyc, stall_breaks, valid_seen;
   bit prev_stall, prev_ready;
   logic [VW-1:0] prev_v;
   logic [HW-1:0] prev_h;

   topview_line_raster dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .ready      (ready),
      .line_num   (line_num),
      .raddr      (raddr),
      .rd_start_v (rd_start_v),
      .rd_end_v   (rd_end_v),
      .rd_start_h (rd_start_h),
      .rd_end_h   (rd_end_h),
      .rd_valid   (rd_valid),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_v      (pix_v),
      .pix_h      (pix_h),
      .busy       (busy),
      .done       (done),
      .seg_drawn  (seg_drawn)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Segment-table BRAM: registered address, data one cycle later.
   always @(posedge clk) begin
      rd_start_v <= tbl[raddr[3:0]].v0;
      rd_start_h <= tbl[raddr[3:0]].h0;
      rd_end_v   <= tbl[raddr[3:0]].v1;
      rd_end_h   <= tbl[raddr[3:0]].h1;
      rd_valid   <= tbl[raddr[3:0]].valid;
   end

   function automatic int pk(input int v, input int h);
      return v * 1024 + h;
   endfunction

   always @(negedge clk) begin
      if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pix_valid) valid_seen++;
      if (prev_stall && prev_ready && (!pix_valid || pix_v != prev_v || pix_h != prev_h)) stall_breaks++;
      prev_stall = pix_valid && !pix_ready;
      prev_ready = ready;
      prev_v     = pix_v;
      prev_h     = pix_h;
      if (pix_valid && pix_ready) begin
         got_q.push_back(pk(int'(pix_v), int'(pix_h)));
         last_acc_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy && (raddr_q.size() == 0 || raddr_q[$] != int'(raddr))) raddr_q.push_back(int'(raddr));
   end

   task automatic clear_mon();
      got_q.delete();
      raddr_q.delete();
      done_cnt = 0; done_cyc = -1; last_acc_cyc = -1; first_valid_cyc = -1;
      stall_breaks = 0; valid_seen = 0; prev_stall = 0;
   endtask

   task automatic set_entry(input int i, input int v0, input int h0, input int v1, input int h1, input bit vld);
      tbl[i].v0 = VW'(v0); tbl[i].h0 = HW'(h0);
      tbl[i].v1 = VW'(v1); tbl[i].h1 = HW'(h1);
      tbl[i].valid = vld;
   endtask

   // Reference rasterizer: textbook integer Bresenham over plain ints.
   task automatic ref_seg(input int v0, input int h0, input int v1, input int h1);
      int dx, dy, sh, sv, err, e2, v, h;
      dx  = (h1 > h0) ? h1 - h0 : h0 - h1;
      dy  = -((v1 > v0) ? v1 - v0 : v0 - v1);
      sh  = (h0 < h1) ? 1 : -1;
      sv  = (v0 < v1) ? 1 : -1;
      err = dx + dy;
      v = v0; h = h0;
      for (int k = 0; k < 2000; k++) begin
         exp_q.push_back(pk(v, h));
         if (v == v1 && h == h1) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; h += sh; end
         if (e2 <= dx) begin err += dx; v += sv; end
      end
   endtask

   task automatic build_exp(input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++)
         if (tbl[i].valid) ref_seg(int'(tbl[i].v0), int'(tbl[i].h0), int'(tbl[i].v1), int'(tbl[i].h1));
   endtask

   // Starts a walk and drives pix_ready (0: held high, 1: toggling, 2: random) until done or budget.
   task automatic run_walk(input int n, input int mode, input int max_cyc, output int ready_cyc, output bit timed_out);
      clear_mon();
      line_num = AW'(n);
      @(posedge clk); #1;
      ready     = 1'b1;
      ready_cyc = cyc;
      pix_ready = (mode == 2) ? 1'($urandom_range(1)) : 1'b1;
      for (int i = 0; i < max_cyc && done_cnt == 0; i++) begin
         @(posedge clk); #1;
         if (mode == 1) pix_ready = ~pix_ready;
         else if (mode == 2) pix_ready = 1'($urandom_range(1));
      end
      timed_out = (done_cnt == 0);
   endtask

   task automatic end_walk();
      repeat (2) @(posedge clk);
      #1 ready = 1'b0;
      pix_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0; ready = 1'b0; pix_ready = 1'b0; line_num = '0;
      for (int i = 0; i < 16; i++) set_entry(i, 0, 0, 0, 0, 1'b0);
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (raddr !== '0)     begin n_fail++; $display("FAIL reset_raddr: got %0d want 0", raddr); end
      n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
      n_checks++; if (pix_v !== '0)     begin n_fail++; $display("FAIL reset_pix_v: got %0d want 0", pix_v); end
      n_checks++; if (pix_h !== '0)     begin n_fail++; $display("FAIL reset_pix_h: got %0d want 0", pix_h); end
      n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (seg_drawn !== '0) begin n_fail++; $display("FAIL reset_seg_drawn: got %0d want 0", seg_drawn); end
      n_rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_horizontal();
      int rc; bit to;
      int e[4];
      e = '{pk(5, 10), pk(5, 11), pk(5, 12), pk(5, 13)};
      set_entry(0, 5, 10, 5, 13, 1'b1);
      run_walk(1, 0, 200, rc, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL horiz_timeout: done_cnt %0d want >0", done_cnt); end
      n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL horiz_len: got %0d want 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] != e[i]) begin n_fail++; $display("FAIL horiz_pix%0d: got %0d want %0d", i, got_q[i], e[i]); end
      end
      n_checks++; if (first_valid_cyc - rc != 3) begin n_fail++; $display("FAIL horiz_first_latency: got %0d want 3", first_valid_cyc - rc); end
      n_checks++; if (done_cyc - last_acc_cyc != 1) begin n_fail++; $display("FAIL horiz_done_latency: got %0d want 1", done_cyc - last_acc_cyc); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL horiz_done_cnt: got %0d want 1", done_cnt); end
      n_checks++; if (seg_drawn !== AW'(1)) begin n_fail++; $display("FAIL horiz_seg_drawn: got %0d want 1", seg_drawn); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL horiz_busy_after: got %b want 0", busy); end
      end_walk();
   endtask

   task automatic test_diag_stall();
      int rc; bit to;
      int e[4];
      e = '{pk(0, 0), pk(1, 1), pk(2, 2), pk(3, 3)};
      set_entry(0, 0, 0, 3, 3, 1'b1);
      run_walk(1, 1, 200, rc, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL diag_timeout: done_cnt %0d want >0", done_cnt); end
      n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL diag_len: got %0d want 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] != e[i]) begin n_fail++; $display("FAIL diag_pix%0d: got %0d want %0d", i, got_q[i], e[i]); end
      end
      n_checks++; if (stall_breaks != 0) begin n_fail++; $display("FAIL diag_stall_hold: got %0d breaks want 0", stall_breaks); end
      n_checks++; if (seg_drawn !== AW'(1)) begin n_fail++; $display("FAIL diag_seg_drawn: got %0d want 1", seg_drawn); end
      end_walk();
   endtask

   task automatic test_steep();
      int rc; bit to; int v;
      set_entry(0, 10, 8, 4, 6, 1'b1);
      build_exp(1);
      run_walk(1, 2, 300, rc, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL steep_timeout: done_cnt %0d want >0", done_cnt); end
      n_checks++; if (got_q.size() != 7) begin n_fail++; $display("FAIL steep_len: got %0d want 7", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 7; i++) begin
         v = got_q[i] / 1024;
         n_checks++;
         if (v != 10 - i) begin n_fail++; $display("FAIL steep_v%0d: got %0d want %0d", i, v, 10 - i); end
      end
      if (got_q.size() > 0) begin
         n_checks++;
         if (got_q[$] % 1024 != 6) begin n_fail++; $display("FAIL steep_last_h: got %0d want 6", got_q[$] % 1024); end
      end
      n_checks++;
      if (got_q != exp_q) begin n_fail++; $display("FAIL steep_model: got %0d pixels want %0d pixels", got_q.size(), exp_q.size()); end
      n_checks++; if (stall_breaks != 0) begin n_fail++; $display("FAIL steep_stall_hold: got %0d breaks want 0", stall_breaks); end
      end_walk();
   endtask

   task automatic test_skip();
      int rc; bit to;
      set_entry(0, 20, 30, 25, 41, 1'b1);
      set_entry(1, 100, 100, 200, 200, 1'b0);
      set_entry(2, 50, 60, 44, 57, 1'b1);
      build_exp(3);
      run_walk(3, 2, 500, rc, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL skip_timeout: done_cnt %0d want >0", done_cnt); end
      n_checks++;
      if (raddr_q.size() != 3 || raddr_q[0] != 0 || raddr_q[1] != 1 || raddr_q[2] != 2) begin
         n_fail++; $display("FAIL skip_raddr_seq: got %0d addresses (first %0d) want 0,1,2", raddr_q.size(), (raddr_q.size() > 0) ? raddr_q[0] : -1);
      end
      n_checks++; if (seg_drawn !== AW'(2)) begin n_fail++; $display("FAIL skip_seg_drawn: got %0d want 2", seg_drawn); end
      n_checks++; if (got_q != exp_q) begin n_fail++; $display("FAIL skip_model: got %0d pixels want %0d pixels", got_q.size(), exp_q.size()); end
      end_walk();
   endtask

   task automatic test_abort();
      int rc; bit to; bit reached;
      set_entry(0, 7, 7, 7, 9, 1'b1);
      set_entry(1, 0, 0, 0, 20, 1'b1);
      clear_mon();
      line_num = AW'(2);
      @(posedge clk); #1;
      ready = 1'b1; pix_ready = 1'b1;
      reached = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (got_q.size() >= 6) begin reached = 1; break; end
      end
      n_checks++; if (!reached) begin n_fail++; $display("FAIL abort_reach: got %0d pixels want 6", got_q.size()); end
      ready = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL abort_pix_valid: got %b want 0", pix_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
      repeat (5) @(posedge clk);
      #1;
      n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
      n_checks++; if (seg_drawn !== AW'(1)) begin n_fail++; $display("FAIL abort_seg_hold: got %0d want 1", seg_drawn); end
      build_exp(2);
      run_walk(2, 0, 200, rc, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL abort_restart_timeout: done_cnt %0d want >0", done_cnt); end
      n_checks++;
      if (raddr_q.size() == 0 || raddr_q[0] != 0) begin
         n_fail++; $display("FAIL abort_restart_raddr: got %0d want 0", (raddr_q.size() > 0) ? raddr_q[0] : -1);
      end
      n_checks++; if (got_q != exp_q) begin n_fail++; $display("FAIL abort_restart_model: got %0d pixels want %0d pixels", got_q.size(), exp_q.size()); end
      n_checks++; if (seg_drawn !== AW'(2)) begin n_fail++; $display("FAIL abort_restart_seg_drawn: got %0d want 2", seg_drawn); end
      end_walk();
   endtask

   task automatic test_empty();
      int rc; bit to;
      run_walk(0, 0, 20, rc, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL empty_timeout: done_cnt %0d want >0", done_cnt); end
      n_checks++;
      if (done_cyc - rc < 1 || done_cyc - rc > 2) begin n_fail++; $display("FAIL empty_done_latency: got %0d want 1..2", done_cyc - rc); end
      repeat (10) @(posedge clk);
      #1;
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL empty_single_walk: got %0d done pulses want 1", done_cnt); end
      n_checks++; if (valid_seen != 0) begin n_fail++; $display("FAIL empty_no_pixels: got %0d want 0", valid_seen); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy: got %b want 0", busy); end
      end_walk();
   endtask

   task automatic test_random();
      int rc; bit to; int n, nvalid, exp_len, dv, dh;
      for (int w = 0; w < 3; w++) begin
         n = 2 + $urandom_range(3);
         nvalid = 0; exp_len = 0;
         for (int i = 0; i < n; i++) begin
            set_entry(i, $urandom_range(TV_OUT_HEIGHT - 1), $urandom_range(TV_OUT_WIDTH - 1),
                      $urandom_range(TV_OUT_HEIGHT - 1), $urandom_range(TV_OUT_WIDTH - 1), ($urandom_range(4) != 0));
            if (tbl[i].valid) begin
               nvalid++;
               dv = int'(tbl[i].v1) - int'(tbl[i].v0); if (dv < 0) dv = -dv;
               dh = int'(tbl[i].h1) - int'(tbl[i].h0); if (dh < 0) dh = -dh;
               exp_len += ((dv > dh) ? dv : dh) + 1;
            end
         end
         build_exp(n);
         run_walk(n, 2, 20000, rc, to);
         n_checks++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout: done_cnt %0d want >0", w, done_cnt); end
         n_checks++; if (got_q.size() != exp_len) begin n_fail++; $display("FAIL rand%0d_len: got %0d want %0d", w, got_q.size(), exp_len); end
         n_checks++; if (got_q != exp_q) begin n_fail++; $display("FAIL rand%0d_model: got %0d pixels want %0d pixels", w, got_q.size(), exp_q.size()); end
         n_checks++; if (seg_drawn !== AW'(nvalid)) begin n_fail++; $display("FAIL rand%0d_seg_drawn: got %0d want %0d", w, seg_drawn, nvalid); end
         n_checks++; if (stall_breaks != 0) begin n_fail++; $display("FAIL rand%0d_stall_hold: got %0d breaks want 0", w, stall_breaks); end
         end_walk();
      end
   endtask

   initial begin
      test_reset();
      test_horizontal();
      test_diag_stall();
      test_steep();
      test_skip();
      test_abort();
      test_empty();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
